// File: rtl/seg7_pkg.sv
// Shared glyph constants and FSM state type for the binary-to-seven-segment display path.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_UPDATE
  } state_t;

  // Map one BCD digit to its glyph; codes 10..15 never come out of the converter and show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One decimal digit to one active-low seven-segment glyph, with a blank override
// used by the leading-zero suppression chain in the top level.
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the digit value; otherwise look up the glyph.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg = glyph(bcd);
    end
  end

endmodule

// File: rtl/bin_to_7seg_display.sv
// Iterative binary-to-decimal converter (double-dabble, one bit per clock) driving
// DIGITS active-low seven-segment displays with leading-zero blanking and overflow dashes.
// Flow: IDLE -> SHIFT (BIN_W cycles) -> UPDATE (1 cycle) -> IDLE.
module bin_to_7seg_display
  import seg7_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1,
  parameter int AUTO     = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BIN_W-1:0]    VALUE,
  input  logic                LOAD,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVF,
  output logic [7*DIGITS-1:0] SEG
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  // Compare width is at least 32 so 10**DIGITS-1 always fits, even for narrow VALUE.
  localparam int CMP_W = (BIN_W > 32) ? BIN_W : 32;
  localparam logic [CMP_W-1:0] MAX_DEC = CMP_W'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_W-1:0]     bin_sr;
  logic [BIN_W-1:0]     val_lat;
  logic [BIN_W-1:0]     last_val;
  logic [BCD_W-1:0]     bcd;
  logic                 ovf_pend;
  logic                 start;
  logic [DIGITS-1:0]    blank_d;
  logic [7*DIGITS-1:0]  seg_enc;

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Start request: explicit LOAD, or in AUTO mode any difference from the last converted value.
  always_comb begin
    start = LOAD;
    if (AUTO != 0 && VALUE != last_val) begin
      start = 1'b1;
    end
  end

  // Leading-zero chain walked from the top digit down; digit 0 is never blanked.
  always_comb begin
    logic run;
    run = (BLANK_LZ != 0);
    blank_d = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run && (bcd[4*k +: 4] == 4'd0);
      blank_d[k] = run && (k > 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_digit_enc u_enc (
      .bcd   (bcd[4*g +: 4]),
      .blank (blank_d[g]),
      .seg   (seg_enc[7*g +: 7])
    );
  end

  // Control FSM with registered BUSY/DONE/OVF/SEG; reset returns the displays to dashes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVF      <= 1'b0;
      SEG      <= {DIGITS{SEG_DASH}};
      last_val <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            cnt   <= CNT_LOAD;
            BUSY  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          SEG      <= ovf_pend ? {DIGITS{SEG_DASH}} : seg_enc;
          OVF      <= ovf_pend;
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
          last_val <= val_lat;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift/BCD datapath: load on the start edge, one add-3-and-shift step per SHIFT cycle.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && start) begin
      bin_sr   <= VALUE;
      val_lat  <= VALUE;
      bcd      <= '0;
      ovf_pend <= (CMP_W'(VALUE) > MAX_DEC);
    end else if (state == ST_SHIFT) begin
      {bcd, bin_sr} <= {add3(bcd), bin_sr} << 1;
    end
  end

endmodule

// File: tb/tb_bin_to_7seg_display.sv
// Self-checking bench for bin_to_7seg_display: four instances cover the default
// configuration, a two-digit overflow case, AUTO mode and shown leading zeros.
module tb_bin_to_7seg_display;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;

  typedef struct {
    logic [7:0]  v;
    logic [20:0] seg;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [20:0] seg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  load_i;
  logic [7:0]  val_a, val_b, val_c, val_d;
  wire  [3:0]  busy_w, done_w, ovf_w;
  wire  [20:0] seg_a, seg_c, seg_d;
  wire  [13:0] seg_b;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tab[10];

  always #5 clk = ~clk;

  bin_to_7seg_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1), .AUTO(0)) u_a (
    .CLK(clk), .RST(rst), .VALUE(val_a), .LOAD(load_i[0]),
    .BUSY(busy_w[0]), .DONE(done_w[0]), .OVF(ovf_w[0]), .SEG(seg_a));

  bin_to_7seg_display #(.BIN_W(8), .DIGITS(2), .BLANK_LZ(1), .AUTO(0)) u_b (
    .CLK(clk), .RST(rst), .VALUE(val_b), .LOAD(load_i[1]),
    .BUSY(busy_w[1]), .DONE(done_w[1]), .OVF(ovf_w[1]), .SEG(seg_b));

  bin_to_7seg_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1), .AUTO(1)) u_c (
    .CLK(clk), .RST(rst), .VALUE(val_c), .LOAD(load_i[2]),
    .BUSY(busy_w[2]), .DONE(done_w[2]), .OVF(ovf_w[2]), .SEG(seg_c));

  bin_to_7seg_display #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(0), .AUTO(0)) u_d (
    .CLK(clk), .RST(rst), .VALUE(val_d), .LOAD(load_i[3]),
    .BUSY(busy_w[3]), .DONE(done_w[3]), .OVF(ovf_w[3]), .SEG(seg_d));

  function automatic logic [20:0] seg_of(input int u);
    case (u)
      0:       return seg_a;
      1:       return {7'b0, seg_b};
      2:       return seg_c;
      default: return seg_d;
    endcase
  endfunction

  task automatic set_val(input int u, input logic [7:0] v);
    case (u)
      0:       val_a = v;
      1:       val_b = v;
      2:       val_c = v;
      default: val_d = v;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one LOAD pulse, expect DONE after BIN_W+1 edges, compare against the scoreboard.
  task automatic run_conv(input int u, input logic [7:0] v, input logic [20:0] eseg,
                          input logic eovf, input string name);
    int   cyc;
    exp_t e;
    sb.push_back('{seg: eseg, ovf: eovf});
    set_val(u, v);
    load_i[u] = 1'b1;
    @(negedge clk);
    load_i[u] = 1'b0;
    cyc = 1;
    chk({name, "_busy"}, 32'(busy_w[u]), 32'd1);
    while (done_w[u] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    if (done_w[u] !== 1'b1) begin
      chk({name, "_done_timeout"}, 32'(done_w[u]), 32'd1);
    end else begin
      chk({name, "_latency"}, 32'(cyc - 1), 32'd9);
      chk({name, "_seg"}, 32'(seg_of(u)), 32'(e.seg));
      chk({name, "_ovf"}, 32'(ovf_w[u]), 32'(e.ovf));
      chk({name, "_busy_end"}, 32'(busy_w[u]), 32'd0);
      @(negedge clk);
      chk({name, "_done_pulse"}, 32'(done_w[u]), 32'd0);
    end
  endtask

  initial begin
    int         cyc;
    int         ndone;
    logic [20:0] first_seg;
    logic [20:0] second_seg;

    tab[0] = '{8'd0,   {GB, GB, G0}, 1'b0};
    tab[1] = '{8'd255, {G2, G5, G5}, 1'b0};
    tab[2] = '{8'd10,  {GB, G1, G0}, 1'b0};
    tab[3] = '{8'd7,   {GB, GB, G7}, 1'b0};
    tab[4] = '{8'd100, {G1, G0, G0}, 1'b0};
    tab[5] = '{8'd99,  {GB, G9, G9}, 1'b0};
    tab[6] = '{8'd128, {G1, G2, G8}, 1'b0};
    tab[7] = '{8'd201, {G2, G0, G1}, 1'b0};
    tab[8] = '{8'd1,   {GB, GB, G1}, 1'b0};
    tab[9] = '{8'd64,  {GB, G6, G4}, 1'b0};

    rst = 1'b1;
    load_i = '0;
    val_a = '0; val_b = '0; val_c = '0; val_d = '0;
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("reset_seg%0d", u), 32'(seg_of(u)),
          (u == 1) ? 32'({GD, GD}) : 32'({GD, GD, GD}));
      chk($sformatf("reset_busy%0d", u), 32'(busy_w[u]), 32'd0);
      chk($sformatf("reset_done%0d", u), 32'(done_w[u]), 32'd0);
      chk($sformatf("reset_ovf%0d", u), 32'(ovf_w[u]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_conv(0, tab[i].v, tab[i].seg, tab[i].ovf, $sformatf("vec%0d", i));
    end

    run_conv(1, 8'd100, {7'b0, GD, GD}, 1'b1, "d2_100");
    run_conv(1, 8'd99,  {7'b0, G9, G9}, 1'b0, "d2_99");
    run_conv(1, 8'd5,   {7'b0, GB, G5}, 1'b0, "d2_5");
    run_conv(1, 8'd255, {7'b0, GD, GD}, 1'b1, "d2_255");

    run_conv(3, 8'd7,   {G0, G0, G7}, 1'b0, "lz_7");
    run_conv(3, 8'd0,   {G0, G0, G0}, 1'b0, "lz_0");
    run_conv(3, 8'd205, {G2, G0, G5}, 1'b0, "lz_205");

    // LOAD held high for the whole conversion, VALUE changed midway.
    val_a = 8'd3;
    load_i[0] = 1'b1;
    cyc = 0;
    while (done_w[0] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) val_a = 8'd77;
    end
    load_i[0] = 1'b0;
    chk("hold_done_seen", 32'(done_w[0]), 32'd1);
    chk("hold_seg", 32'(seg_a), 32'({GB, GB, G3}));
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) ndone++;
    end
    chk("hold_no_second", 32'(ndone), 32'd0);
    chk("hold_seg_after", 32'(seg_a), 32'({GB, GB, G3}));

    // AUTO: VALUE 5 then 6 during the conversion gives two completions.
    val_c = 8'd5;
    ndone = 0;
    first_seg = '0;
    second_seg = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) val_c = 8'd6;
      if (done_w[2] === 1'b1) begin
        ndone++;
        if (ndone == 1) first_seg = seg_c;
        if (ndone == 2) second_seg = seg_c;
      end
    end
    chk("auto_done_count", 32'(ndone), 32'd2);
    chk("auto_first", 32'(first_seg), 32'({GB, GB, G5}));
    chk("auto_second", 32'(second_seg), 32'({GB, GB, G6}));

    // AUTO=0 instance must not start on a VALUE change alone.
    val_a = 8'd42;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) ndone++;
    end
    chk("noauto_idle", 32'(ndone), 32'd0);

    // Reset sampled on the 4th SHIFT edge aborts the conversion.
    val_a = 8'd123;
    load_i[0] = 1'b1;
    @(negedge clk);
    load_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    chk("abort_seg", 32'(seg_a), 32'({GD, GD, GD}));
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_seg_hold", 32'(seg_a), 32'({GD, GD, GD}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
